mc_core_ctrl: RTL and testbench

Multi-cycle control sequencer for the next NPC core. It replaces the single-cycle, combinational fetch/execute/writeback flow with a state machine. The sequencer talks to the instruction fetch unit and the LSU over valid/ready handshakes with variable latency. It owns the PC, sequences GPR writeback, counts retired instructions, and halts on ebreak, illegal instruction, misaligned jump, bus error or bus timeout.

---
 rtl/mc_core_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_mc_core_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_core_ctrl.sv
// Multi-cycle control sequencer for the NPC core.
// Sequences fetch -> execute -> (memory) -> writeback over valid/ready
// handshakes with the IFU and LSU, owns the PC and retire counter, and
// parks in a sticky HALT state on ebreak, illegal/misaligned control flow,
// bus errors or a bus watchdog timeout.
module mc_core_ctrl #(
  parameter int              XLEN           = 32,
  parameter logic [XLEN-1:0] RESET_PC       = 32'h8000_0000,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter int              TO_W           = 8
) (
  input  logic            clk,
  input  logic            rst,
  // instruction fetch
  output logic            ifu_req_valid,
  input  logic            ifu_req_ready,
  output logic [XLEN-1:0] ifu_req_addr,
  input  logic            ifu_resp_valid,
  input  logic [31:0]     ifu_resp_inst,
  input  logic            ifu_resp_err,
  output logic [31:0]     inst_q,
  // decode / execute
  input  logic            dec_is_mem,
  input  logic            dec_rd_wen,
  input  logic            dec_is_jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            dec_is_ebreak,
  input  logic            dec_illegal,
  // load/store unit
  output logic            lsu_req_valid,
  input  logic            lsu_req_ready,
  input  logic            lsu_resp_valid,
  input  logic            lsu_resp_err,
  // writeback / status
  output logic            gpr_wen,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] retire_cnt,
  output logic            halt,
  output logic [1:0]      halt_code
);

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    EXEC,
    MEM_REQ,
    MEM_WAIT,
    WB,
    HALT
  } state_t;

  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_BUS     = 2'd3;

  localparam logic [TO_W:0] TO_LIMIT = (TO_W + 1)'(TIMEOUT_CYCLES);
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

  state_t          state;
  logic [TO_W-1:0] wdog;
  logic [TO_W:0]   wdog_inc;
  logic            wdog_expire;
  logic            jump_misaligned;

  // The cycle being spent now is the (wdog+1)-th without a handshake; if that
  // reaches the limit the phase is abandoned (a handshake this cycle wins).
  assign wdog_inc        = {1'b0, wdog} + (TO_W + 1)'(1);
  assign wdog_expire     = TO_EN && (wdog_inc == TO_LIMIT);
  assign jump_misaligned = dec_is_jump && (jump_target[1:0] != 2'b00);

  // Handshake strobes are pure state decodes so they drop the moment the FSM moves.
  assign ifu_req_valid = (state == FETCH_REQ);
  assign ifu_req_addr  = pc;
  assign lsu_req_valid = (state == MEM_REQ);
  assign gpr_wen       = (state == WB) && dec_rd_wen;

  // Sequencer: state, PC, instruction latch, retire counter, halt status, watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH_REQ;
      pc         <= RESET_PC;
      inst_q     <= '0;
      retire_cnt <= '0;
      halt       <= 1'b0;
      halt_code  <= 2'd0;
      wdog       <= '0;
    end else begin
      case (state)
        FETCH_REQ: begin
          if (ifu_req_ready) begin
            state <= FETCH_WAIT;
            wdog  <= '0;
          end else if (wdog_expire) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_BUS;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        FETCH_WAIT: begin
          if (ifu_resp_valid) begin
            wdog <= '0;
            if (ifu_resp_err) begin
              state     <= HALT;
              halt      <= 1'b1;
              halt_code <= HC_BUS;
            end else begin
              inst_q <= ifu_resp_inst;
              state  <= EXEC;
            end
          end else if (wdog_expire) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_BUS;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        EXEC: begin
          wdog <= '0;
          if (dec_illegal) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_ILLEGAL;
          end else if (dec_is_ebreak) begin
            retire_cnt <= retire_cnt + 1'b1;
            state      <= HALT;
            halt       <= 1'b1;
            halt_code  <= HC_EBREAK;
          end else if (jump_misaligned) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_ILLEGAL;
          end else if (dec_is_mem) begin
            state <= MEM_REQ;
          end else begin
            state <= WB;
          end
        end

        MEM_REQ: begin
          if (lsu_req_ready) begin
            state <= MEM_WAIT;
            wdog  <= '0;
          end else if (wdog_expire) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_BUS;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        MEM_WAIT: begin
          if (lsu_resp_valid) begin
            wdog <= '0;
            if (lsu_resp_err) begin
              state     <= HALT;
              halt      <= 1'b1;
              halt_code <= HC_BUS;
            end else begin
              state <= WB;
            end
          end else if (wdog_expire) begin
            state     <= HALT;
            halt      <= 1'b1;
            halt_code <= HC_BUS;
            wdog      <= '0;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end

        WB: begin
          pc         <= dec_is_jump ? jump_target : pc + XLEN'(4);
          retire_cnt <= retire_cnt + 1'b1;
          state      <= FETCH_REQ;
          wdog       <= '0;
        end

        HALT: begin
          state <= HALT;
        end

        default: begin
          state     <= HALT;
          halt      <= 1'b1;
          halt_code <= HC_ILLEGAL;
          wdog      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_core_ctrl.sv
// Scoreboard bench for mc_core_ctrl: a driver plays IFU, IDU and LSU with
// chosen latencies; a reference model predicts fetches, GPR writes and halts
// (including the cycle each occurs) into queues that a monitor drains.
module tb_mc_core_ctrl;

  localparam int          TO  = 8;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid, ifu_req_ready = 1'b0;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid = 1'b0;
  logic [31:0] ifu_resp_inst = '0;
  logic        ifu_resp_err = 1'b0;
  logic [31:0] inst_q;
  logic        dec_is_mem, dec_rd_wen, dec_is_jump, dec_is_ebreak, dec_illegal;
  logic [31:0] jump_target;
  logic        lsu_req_valid, lsu_req_ready = 1'b0;
  logic        lsu_resp_valid = 1'b0, lsu_resp_err = 1'b0;
  logic        gpr_wen;
  logic [31:0] pc, retire_cnt;
  logic        halt;
  logic [1:0]  halt_code;

  always #5 clk = ~clk;

  mc_core_ctrl #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_inst(ifu_resp_inst), .ifu_resp_err(ifu_resp_err),
    .inst_q(inst_q),
    .dec_is_mem(dec_is_mem), .dec_rd_wen(dec_rd_wen), .dec_is_jump(dec_is_jump),
    .jump_target(jump_target), .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_err(lsu_resp_err),
    .gpr_wen(gpr_wen), .pc(pc), .retire_cnt(retire_cnt), .halt(halt), .halt_code(halt_code)
  );

  // Toy IDU: instruction bit fields carry the decode attributes directly.
  assign dec_is_mem    = inst_q[0];
  assign dec_rd_wen    = inst_q[1];
  assign dec_is_jump   = inst_q[2];
  assign dec_is_ebreak = inst_q[3];
  assign dec_illegal   = inst_q[4];
  assign jump_target   = RPC + {16'h0, inst_q[23:8]};

  typedef struct packed {
    bit mem, wen, jmp, ebk, ill, ferr, lerr, rst_mw;
    logic [15:0] off;
    int d, r, ld, lr;
  } desc_t;

  typedef struct packed { logic [31:0] a; logic [31:0] r; int c; } ev_t;
  typedef struct packed { logic [1:0] code; logic [31:0] p; logic [31:0] r; int c; } hv_t;

  ev_t   fetch_q[$];
  ev_t   wb_q[$];
  hv_t   halt_q[$];
  desc_t prog[$];

  int errors = 0;
  int checks = 0;

  logic [31:0] mpc;
  logic [31:0] mret;
  int          t;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int  cyc   = 0;
    int  hrun  = 0;
    bit  phalt = 0;
    bit  ipend = 0;
    bit  lpend = 0;
    logic [31:0] paddr = '0;
    ev_t e;
    hv_t h;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0; hrun = 0; phalt = 0; ipend = 0; lpend = 0;
      end else begin
        cyc++;
        if (cyc == 1) begin
          chk("rst_pc", pc, RPC);
          chk("rst_retire", retire_cnt, 0);
          chk("rst_halt", {halt, halt_code}, 0);
          chk("rst_inst_q", inst_q, 0);
          chk("rst_strobes", {ifu_req_valid, lsu_req_valid, gpr_wen}, 3'b100);
        end
        if (ipend && !halt) begin
          chk("ifu_hold_valid", ifu_req_valid, 1);
          chk("ifu_hold_addr", ifu_req_addr, paddr);
        end
        if (lpend && !halt) chk("lsu_hold_valid", lsu_req_valid, 1);
        if (ifu_req_valid && ifu_req_ready) begin
          if (fetch_q.size() == 0) chk("fetch_unexpected", ifu_req_addr, 64'hFFFF_FFFF_FFFF);
          else begin
            e = fetch_q.pop_front();
            chk("fetch_addr", ifu_req_addr, e.a);
            chk("fetch_retire", retire_cnt, e.r);
            chk("fetch_cycle", cyc, e.c);
          end
        end
        if (gpr_wen) begin
          if (wb_q.size() == 0) chk("wb_unexpected", pc, 64'hFFFF_FFFF_FFFF);
          else begin
            e = wb_q.pop_front();
            chk("wb_pc", pc, e.a);
            chk("wb_retire", retire_cnt, e.r);
            chk("wb_cycle", cyc, e.c);
          end
        end
        if (halt && !phalt) begin
          if (halt_q.size() == 0) chk("halt_unexpected", halt_code, 64'hFF);
          else begin
            h = halt_q.pop_front();
            chk("halt_code", halt_code, h.code);
            chk("halt_pc", pc, h.p);
            chk("halt_retire", retire_cnt, h.r);
            chk("halt_cycle", cyc, h.c);
          end
        end
        if (halt) begin
          chk("halt_quiet", {ifu_req_valid, lsu_req_valid, gpr_wen}, 0);
          hrun++;
          if (hrun == 3)
            chk("queues_drained", {fetch_q.size(), wb_q.size(), halt_q.size()}, 0);
        end else hrun = 0;
        ipend = ifu_req_valid && !ifu_req_ready;
        lpend = lsu_req_valid && !lsu_req_ready;
        paddr = ifu_req_addr;
        phalt = halt;
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    fetch_q.delete(); wb_q.delete(); halt_q.delete();
    mpc = RPC; mret = 0; t = 1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_err = 0;
    lsu_req_ready = 0; lsu_resp_valid = 0; lsu_resp_err = 0;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  function automatic void push_h(logic [1:0] code, logic [31:0] r, int c);
    halt_q.push_back('{code, mpc, r, c});
  endfunction

  // Predict the outcome of one instruction from its attributes and latencies.
  function automatic bit predict(desc_t x);
    int s, w, e, mr, mw, wbc;
    bit mis;
    s   = t;
    mis = x.jmp && (x.off[1:0] != 2'b00);
    if (x.d >= TO) begin push_h(3, mret, s + TO); return 1; end
    fetch_q.push_back('{mpc, mret, s + x.d});
    w = s + x.d + 1;
    if (x.r >= TO) begin push_h(3, mret, w + TO); return 1; end
    if (x.ferr)    begin push_h(3, mret, w + x.r + 1); return 1; end
    e = w + x.r + 1;
    if (x.ill) begin push_h(2, mret, e + 1); return 1; end
    if (x.ebk) begin push_h(1, mret + 1, e + 1); return 1; end
    if (mis)   begin push_h(2, mret, e + 1); return 1; end
    wbc = e + 1;
    if (x.mem) begin
      mr = e + 1;
      if (x.ld >= TO) begin push_h(3, mret, mr + TO); return 1; end
      mw = mr + x.ld + 1;
      if (x.rst_mw) return 0;
      if (x.lr >= TO) begin push_h(3, mret, mw + TO); return 1; end
      if (x.lerr)     begin push_h(3, mret, mw + x.lr + 1); return 1; end
      wbc = mw + x.lr + 1;
    end
    if (x.wen) wb_q.push_back('{mpc, mret, wbc});
    mpc  = x.jmp ? RPC + {16'h0, x.off} : mpc + 32'd4;
    mret = mret + 1;
    t    = wbc + 1;
    return 0;
  endfunction

  task automatic run_inst(desc_t x, output bit halted);
    int n;
    logic [31:0] inst;
    bit mis;
    mis    = x.jmp && (x.off[1:0] != 2'b00);
    halted = predict(x);
    inst   = {8'($urandom), x.off, 3'($urandom), x.ill, x.ebk, x.jmp, x.wen, x.mem};
    n = 0;
    while (!ifu_req_valid && n < 40) begin step(); n++; end
    chk("fetch_req_seen", ifu_req_valid, 1);
    if (x.d >= TO) return;
    repeat (x.d) step();
    ifu_req_ready = 1; step(); ifu_req_ready = 0;
    if (x.r >= TO) return;
    repeat (x.r) step();
    ifu_resp_valid = 1; ifu_resp_inst = inst; ifu_resp_err = x.ferr;
    step();
    ifu_resp_valid = 0; ifu_resp_err = 0; ifu_resp_inst = $urandom;
    if (x.ferr || x.ill || x.ebk || mis || !x.mem) return;
    // stray fetch responses outside FETCH_WAIT must be ignored
    ifu_resp_valid = 1'($urandom); ifu_resp_err = 1;
    n = 0;
    while (!lsu_req_valid && n < 40) begin step(); n++; end
    chk("lsu_req_seen", lsu_req_valid, 1);
    if (x.ld < TO) begin
      repeat (x.ld) step();
      lsu_req_ready = 1; step(); lsu_req_ready = 0;
      if (x.rst_mw) begin
        repeat (2) step();
        rst = 1; lsu_resp_valid = 1; lsu_resp_err = 1;
        ifu_resp_valid = 0; ifu_resp_err = 0;
        model_reset();
        step();
        rst = 0; lsu_resp_valid = 0; lsu_resp_err = 0;
        return;
      end
      if (x.lr < TO) begin
        repeat (x.lr) step();
        lsu_resp_valid = 1; lsu_resp_err = x.lerr; step();
        lsu_resp_valid = 0; lsu_resp_err = 0;
      end
    end
    ifu_resp_valid = 0; ifu_resp_err = 0;
  endtask

  task automatic run_prog();
    bit h;
    desc_t x;
    int n;
    h = 0;
    while (prog.size() > 0 && !h) begin
      x = prog.pop_front();
      run_inst(x, h);
    end
    prog.delete();
    n = 0;
    while (!halt && n < 300) begin step(); n++; end
    chk("halt_reached", halt, 1);
    ifu_resp_valid = 0; ifu_resp_err = 0;
    repeat (4) step();
    do_reset();
  endtask

  function automatic desc_t mk(bit mem, bit wen, bit jmp, logic [15:0] off);
    desc_t x;
    x = '0;
    x.mem = mem; x.wen = wen; x.jmp = jmp; x.off = off;
    return x;
  endfunction

  function automatic int lat();
    return ($urandom % 10 == 0) ? 6 + int'($urandom % 4) : int'($urandom % 3);
  endfunction

  function automatic desc_t rnd_desc();
    desc_t x;
    x      = '0;
    x.wen  = 1'($urandom);
    x.mem  = ($urandom % 3 == 0);
    x.jmp  = !x.mem && ($urandom % 4 == 0);
    x.off  = 16'($urandom);
    if (x.jmp && ($urandom % 5 != 0)) x.off[1:0] = 2'b00;
    x.ill  = ($urandom % 25 == 0);
    x.ebk  = ($urandom % 25 == 0);
    x.ferr = ($urandom % 30 == 0);
    x.lerr = x.mem && ($urandom % 15 == 0);
    x.d = lat(); x.r = lat(); x.ld = lat(); x.lr = lat();
    return x;
  endfunction

  initial begin
    desc_t x, ebk, ill;
    int n;
    ebk = mk(0, 0, 0, 16'h0); ebk.ebk = 1;
    ill = mk(0, 1, 0, 16'h0); ill.ill = 1;
    do_reset();

    // addi at zero wait, then ebreak
    prog.push_back(mk(0, 1, 0, 16'h0));
    prog.push_back(ebk);
    run_prog();

    // stalled fetch acceptance, aligned jump, misaligned jump
    x = mk(0, 1, 0, 16'h0); x.d = 3; prog.push_back(x);
    prog.push_back(mk(0, 1, 1, 16'h0100));
    prog.push_back(mk(0, 1, 1, 16'h0102));
    run_prog();

    // slow load, store, illegal
    x = mk(1, 1, 0, 16'h0); x.ld = 2; x.lr = 5; prog.push_back(x);
    prog.push_back(mk(1, 0, 0, 16'h0));
    prog.push_back(ill);
    run_prog();

    // fetch response timeout
    x = mk(0, 1, 0, 16'h0); x.r = 8; prog.push_back(x);
    run_prog();

    // response on the limit cycle wins, then LSU bus error
    x = mk(0, 1, 0, 16'h0); x.r = 7; prog.push_back(x);
    x = mk(1, 1, 0, 16'h0); x.lerr = 1; prog.push_back(x);
    run_prog();

    // fetch request timeout, LSU request timeout, LSU response timeout, fetch error
    x = mk(0, 1, 0, 16'h0); x.d = 8; prog.push_back(x); run_prog();
    x = mk(1, 1, 0, 16'h0); x.ld = 8; prog.push_back(x); run_prog();
    x = mk(1, 1, 0, 16'h0); x.lr = 9; prog.push_back(x); run_prog();
    x = mk(0, 1, 0, 16'h0); x.ferr = 1; prog.push_back(x); run_prog();

    // reset during MEM_WAIT, then a fresh run
    x = mk(1, 1, 0, 16'h0); x.lr = 6; x.rst_mw = 1; prog.push_back(x);
    prog.push_back(mk(0, 1, 0, 16'h0));
    prog.push_back(ebk);
    run_prog();

    // randomized programs, each closed by an ebreak
    for (int ep = 0; ep < 40; ep++) begin
      n = 1 + int'($urandom % 8);
      for (int i = 0; i < n; i++) prog.push_back(rnd_desc());
      x = ebk; x.d = lat() % 3; x.r = lat() % 3;
      prog.push_back(x);
      run_prog();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
